hazard_unit_v2: RTL
===================

Name: hazard_unit_v2

Overview:
Parameterised successor to the pipeline hazard unit for the 5-stage MIPS core (F/D/E/M/W). It keeps M/W forwarding, cache/ALU stalls and exception/mispredict flushes. It adds:
- NSRC-operand forwarding, with the $0 guard applied to every operand.
- A D-stage load-use interlock.
- A sticky deferred jump-conflict flush, so no delay-slot instruction is lost.
- A stall watchdog and saturating performance counters.

Parameters:
REG_AW, 5, register index width
NSRC, 2, source operands per instruction (E and D)
CNT_W, 32, performance counter width
TIMEOUT, 1024, consecutive long-stall cycles before watchdog fires (>=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
i_cache_stall  in  1  I-cache miss
d_cache_stall  in  1  D-cache miss
alu_stallE  in  1  multicycle ALU (div/mul) busy in E
flush_jump_conflictE  in  1  jr/jalr conflict redirect from E
flush_pred_failedM  in  1  branch mispredict from M
flush_exceptionM  in  1  exception/eret from M
src_regD  in  NSRC*REG_AW  packed D-stage source indices (operand i at [i*REG_AW +: REG_AW])
src_regE  in  NSRC*REG_AW  packed E-stage source indices
regwriteE, regwriteM, regwriteW  in  1  each  register write enables
mem_readE  in  1  E-stage instruction is a load
writeregE, writeregM, writeregW  in  REG_AW  each  destination indices
stallF, stallD, stallE, stallM, stallW  out  1  each  stage stalls
flushF, flushD, flushE, flushM, flushW  out  1  each  stage flushes
longest_stall  out  1  any cache or ALU stall
forwardE  out  2*NSRC  per operand: 00 none, 01 from M, 10 from W
stall_timeout  out  1  watchdog
stall_cycles  out  CNT_W  saturating count of cycles with stallF=1
flush_events  out  CNT_W  saturating count of cycles with flushD=1

Behaviour:
Combinational terms:
- cache = i_cache_stall|d_cache_stall
- longest_stall = cache|alu_stallE
- exc = flush_exceptionM
- load_use = mem_readE & regwriteE & writeregE!=0 & (any src_regD[i]==writeregE)

Forwarding, per operand i:
- 01 if src!=0 & regwriteM & src==writeregM
- else 10 if src!=0 & regwriteW & src==writeregW
- else 00
- M has priority over W.

Stalls:
- stallF = ~exc & (longest_stall|load_use)
- stallD = longest_stall|load_use
- stallE = longest_stall
- stallM = cache
- stallW = ~exc & cache

Deferred jump flush, register jpend:
- Set when flush_jump_conflictE & stallD & ~exc & ~flush_pred_failedM.
- Cleared on the first cycle with stallD=0; flushD issues that cycle.
- Also cleared by exc or flush_pred_failedM, which supersede it.
- jump_req = flush_jump_conflictE|jpend.

Flushes:
- flushF = 0
- flushD = exc | flush_pred_failedM | (jump_req & ~stallD)
- flushE = exc | (flush_pred_failedM & ~longest_stall) | (load_use & ~longest_stall), where the last term inserts a bubble.
- flushM = exc
- flushW = exc
- When exc and stallD are both asserted, flush wins.

Watchdog:
- Register run counts consecutive cycles with longest_stall=1 and saturates at TIMEOUT.
- run resets to 0 when longest_stall=0.
- stall_timeout = (run==TIMEOUT), registered; first high on the cycle after the TIMEOUT-th consecutive stall cycle.

Counters:
- Increment on the clock edge where the condition holds.
- Saturate at all-ones; no wrap.

Reset (resetn=0 at posedge clk):
- jpend, run, stall_timeout, stall_cycles and flush_events are cleared.
- While resetn=0, outputs are forced: all stall*=0, all flush*=1 except flushF=0, forwardE=0.
- Reset mid-stall drops any pending jump flush.

Test Plan:
- src_regE op0=5, op1=0; regwriteM=1, writeregM=5; regwriteW=1, writeregW=0 -> forwardE[1:0]=01, forwardE[3:2]=00; $0 never forwarded.
- mem_readE=1, regwriteE=1, writeregE=8, src_regD op1=8, no cache stall -> stallF=stallD=1, flushE=1 for exactly 1 cycle; the next cycle has no stall.
- flush_jump_conflictE=1 for 1 cycle while d_cache_stall=1 for 3 cycles -> flushD=0 during the stall, then flushD=1 on the 1st unstalled cycle only; flush_events +1.
- jpend set, then flush_exceptionM=1 while stalled -> flushD/E/M/W=1 immediately, stallF=stallW=0; jpend cleared, no later extra flushD.
- TIMEOUT=4, alu_stallE held 6 cycles -> stall_timeout rises after 4 cycles, drops the cycle after alu_stallE falls; stall_cycles=6.
- CNT_W=3, stallF held 10 cycles -> stall_cycles stays at 7; resetn=0 for one edge -> all counters 0.

Source files
------------

// File: rtl/hazard_unit_v2.sv
// hazard_unit_v2: hazard control for the 5-stage MIPS pipeline (F/D/E/M/W).
// Handles N-operand M/W forwarding, the D-stage load-use interlock, cache and
// ALU stalls, exception/mispredict flushes, a deferred jr/jalr conflict flush
// that waits out a D stall, a long-stall watchdog and saturating counters.
module hazard_unit_v2 #(
    parameter int REG_AW  = 5,
    parameter int NSRC    = 2,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_cache_stall,
    input  logic                     d_cache_stall,
    input  logic                     alu_stallE,
    input  logic                     flush_jump_conflictE,
    input  logic                     flush_pred_failedM,
    input  logic                     flush_exceptionM,
    input  logic [NSRC*REG_AW-1:0]   src_regD,
    input  logic [NSRC*REG_AW-1:0]   src_regE,
    input  logic                     regwriteE,
    input  logic                     regwriteM,
    input  logic                     regwriteW,
    input  logic                     mem_readE,
    input  logic [REG_AW-1:0]        writeregE,
    input  logic [REG_AW-1:0]        writeregM,
    input  logic [REG_AW-1:0]        writeregW,
    output logic                     stallF,
    output logic                     stallD,
    output logic                     stallE,
    output logic                     stallM,
    output logic                     stallW,
    output logic                     flushF,
    output logic                     flushD,
    output logic                     flushE,
    output logic                     flushM,
    output logic                     flushW,
    output logic                     longest_stall,
    output logic [2*NSRC-1:0]        forwardE,
    output logic                     stall_timeout,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         flush_events
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    // Registered state
    logic             r_jpend;
    logic [RUN_W-1:0] r_run;
    logic             r_stall_timeout;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Combinational terms
    logic             w_cache;
    logic             w_longest;
    logic             w_exc;
    logic             w_load_use;
    logic             w_jump_req;
    logic [2*NSRC-1:0] w_fwd;
    logic             w_stallF, w_stallD, w_stallE, w_stallM, w_stallW;
    logic             w_flushD, w_flushE, w_flushM, w_flushW;
    logic [RUN_W-1:0] w_run_next;

    assign w_cache    = i_cache_stall | d_cache_stall;
    assign w_longest  = w_cache | alu_stallE;
    assign w_exc      = flush_exceptionM;
    assign w_jump_req = flush_jump_conflictE | r_jpend;

    // Per-operand forwarding select; M is newer than W so it wins, $0 never forwards
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        w_fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_regE[i*REG_AW +: REG_AW] != '0 && regwriteM &&
                src_regE[i*REG_AW +: REG_AW] == writeregM) begin
                w_fwd[2*i +: 2] = 2'b01;
            end else if (src_regE[i*REG_AW +: REG_AW] != '0 && regwriteW &&
                         src_regE[i*REG_AW +: REG_AW] == writeregW) begin
                w_fwd[2*i +: 2] = 2'b10;
            end
        end
    end

    // Load-use: a D-stage operand needs the value the E-stage load has not fetched yet
    always_comb begin
        w_load_use = 1'b0;
        if (mem_readE && regwriteE && writeregE != '0) begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_regD[i*REG_AW +: REG_AW] == writeregE) begin
                    w_load_use = 1'b1;
                end
            end
        end
    end

    // Stall and flush equations; an exception lets F and W run so the handler fetch proceeds
    always_comb begin
        w_stallF = ~w_exc & (w_longest | w_load_use);
        w_stallD = w_longest | w_load_use;
        w_stallE = w_longest;
        w_stallM = w_cache;
        w_stallW = ~w_exc & w_cache;

        w_flushD = w_exc | flush_pred_failedM | (w_jump_req & ~w_stallD);
        w_flushE = w_exc | (flush_pred_failedM & ~w_longest) | (w_load_use & ~w_longest);
        w_flushM = w_exc;
        w_flushW = w_exc;
    end

    // Next value of the consecutive long-stall run length, saturating at TIMEOUT
    always_comb begin
        w_run_next = '0;
        if (w_longest) begin
            w_run_next = (r_run == RUN_W'(TIMEOUT)) ? r_run : r_run + RUN_W'(1);
        end
    end

    // Deferred jump flush: remember a conflict redirect that arrived while D was stalled
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked block and is sampled on the edge.
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            r_jpend <= 1'b0;
        end else if (w_exc || flush_pred_failedM) begin
            r_jpend <= 1'b0;
        end else if (flush_jump_conflictE && w_stallD) begin
            r_jpend <= 1'b1;
        end else if (!w_stallD) begin
            r_jpend <= 1'b0;
        end
    end

    // Watchdog: raise stall_timeout once the run length reaches TIMEOUT
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_run           <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_run           <= w_run_next;
            r_stall_timeout <= (w_run_next == RUN_W'(TIMEOUT));
        end
    end

    // Saturating performance counters for fetch-stall cycles and decode flushes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stallF && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flushD && r_flush_events != '1) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    // While reset is held the pipeline is frozen-and-cleared: no stalls, flush D..W
    assign stallF        = resetn & w_stallF;
    assign stallD        = resetn & w_stallD;
    assign stallE        = resetn & w_stallE;
    assign stallM        = resetn & w_stallM;
    assign stallW        = resetn & w_stallW;
    assign flushF        = 1'b0;
    assign flushD        = ~resetn | w_flushD;
    assign flushE        = ~resetn | w_flushE;
    assign flushM        = ~resetn | w_flushM;
    assign flushW        = ~resetn | w_flushW;
    assign longest_stall = w_longest;
    assign forwardE      = resetn ? w_fwd : '0;
    assign stall_timeout = r_stall_timeout;
    assign stall_cycles  = r_stall_cycles;
    assign flush_events  = r_flush_events;

endmodule
